map_bram_arbiter: RTL
=====================

Name: map_bram_arbiter

Overview:
- Shares the single port of the map tile BRAM (19-bit address, 16-bit tile ids) between three requesters:
  - 0 = level loader (write bursts)
  - 1 = interaction logic (read-modify-write of one tile)
  - 2 = map renderer (reads)
- Round-robin arbitration with an optional lock, so one requester can do an atomic read-then-write.
- Sits between the requesters and the BRAM port.

Parameters:
- ADDR_W, 19, BRAM address width
- DATA_W, 16, tile data width
- RD_LATENCY, 1, BRAM cycles from address presented to data valid (1..3)
- LOCK_TIMEOUT, 16, idle cycles a lock owner may hold without requesting before forced release

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- req  in  3  per-requester transaction request, bit i = requester i
- wr  in  3  per-requester 1 = write, 0 = read
- lock  in  3  keep grant ownership after this transaction
- addr  in  3*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  3*DATA_W  packed write data, same packing
- gnt  out  3  one-cycle pulse: transaction of requester i issued this cycle
- rvalid  out  3  one-cycle pulse: rdata holds requester i's read result
- rdata  out  DATA_W  registered read data, shared by all requesters
- lock_timeout  out  1  one-cycle pulse when a lock is forcibly released
- bram_map_addr  out  ADDR_W  BRAM address
- bram_map_data  in  DATA_W  BRAM read data
- bram_map_wr  out  1  BRAM write enable
- bram_map_dwrite  out  DATA_W  BRAM write data

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE, no lock owner, RR pointer = 2 (requester 0 has top priority first).
  - Reset mid-transaction drops any in-flight read: no rvalid, no gnt after release.
- Requester contract:
  - Hold req/wr/addr/wdata/lock stable from assertion until the cycle gnt is seen.
  - Deassert req (or present a new transaction) the following cycle.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If lock owner exists: only the owner's req is considered.
  - Otherwise pick the first asserted req after the RR pointer (order ptr+1, ptr+2, ptr, mod 3).
  - Winner k registered at clock edge → next cycle is ISSUE.
- ISSUE (cycle C), registered outputs:
  - gnt[k] = 1; bram_map_addr = addr_k; bram_map_wr = wr_k; bram_map_dwrite = wdata_k.
  - RR pointer ← k.
  - If lock_k is 1, owner ← k; otherwise the owner is cleared.
  - Next state WAIT.
- WAIT:
  - bram_map_wr = 0; bram_map_addr and bram_map_dwrite hold their values.
  - Write: 1 cycle (C+1), then IDLE. The earliest next gnt is C+3.
  - Read: RD_LATENCY cycles. bram_map_data is sampled at the end of cycle C+RD_LATENCY.
  - rdata/rvalid[k] appear in cycle C+RD_LATENCY+1; the state is IDLE in that same cycle.
  - The WAIT cycle guarantees a stale req (still high in C) is never granted twice.
- gnt and rvalid are one-hot or zero; at most one bit is set per cycle.
- Lock:
  - The owner keeps exclusive access across transactions while each granted transaction carries lock = 1.
  - A transaction with lock = 0 releases ownership at its ISSUE.
  - A counter increments each IDLE cycle while an owner exists and req[owner] = 0.
  - When the counter reaches LOCK_TIMEOUT:
    - owner is cleared;
    - lock_timeout pulses for 1 cycle;
    - counter returns to 0.
  - Counter resets on any owner grant.
  - Timeout and a new owner request in the same cycle: the request wins, no timeout.
- Non-owner requests are stalled during a lock, never dropped.
- Address and data pass through unmodified (no width arithmetic); rdata holds its value until the next read completes.

Test Plan:
- Single read, RD_LATENCY = 1: req = 3'b100, addr2 = 0x0012A, BRAM returns 0x0007.
  → gnt[2] at C with bram_map_addr = 0x0012A, bram_map_wr = 0; rvalid[2] with rdata = 0x0007 at C+2.
- Write: req0, wr0 = 1, addr0 = 5, wdata0 = 0x00FF.
  → bram_map_wr = 1 exactly in gnt cycle with dwrite = 0x00FF; no rvalid; next grant no earlier than C+3.
- All three requesting continuously after reset.
  → grant order 0, 1, 2, 0, 1, 2; no requester is ever granted twice consecutively while others wait.
- Lock RMW: req1 read with lock = 1 while req2 is held high; then req1 write with lock = 0.
  → grants: 1 (read), 1 (write), then 2; req2 is never granted between them.
- Lock timeout: req1 read with lock = 1, then req1 idle, req0 high.
  → lock_timeout pulses after 16 idle cycles; gnt[0] follows within 2 cycles.
- Reset during WAIT of a read (rstn low at C+1).
  → all outputs 0, no rvalid afterwards; the first request after release is granted normally.

Source files
------------

// File: rtl/map_bram_arbiter.sv
// Round-robin arbiter with an optional lock in front of the single port of the map tile BRAM.
// Requester 0 = level loader, 1 = interaction logic, 2 = map renderer.
module map_bram_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 16,
  parameter int RD_LATENCY   = 1,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [2:0]          req,
  input  logic [2:0]          wr,
  input  logic [2:0]          lock,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                lock_timeout,
  output logic [ADDR_W-1:0]   bram_map_addr,
  input  logic [DATA_W-1:0]   bram_map_data,
  output logic                bram_map_wr,
  output logic [DATA_W-1:0]   bram_map_dwrite
);

  localparam int               TMO_W     = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [1:0]       WAIT_LAST = 2'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [1:0]       ptr_r;
  logic [1:0]       owner_r;
  logic             owner_valid_r;
  logic [1:0]       cur_r;
  logic             op_wr_r;
  logic [1:0]       wait_cnt_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             win_valid_s;
  logic [1:0]       win_idx_s;
  logic [1:0]       c0_s;
  logic [1:0]       c1_s;
  logic             wait_done_s;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    case (i)
      2'd0:    next_idx = 2'd1;
      2'd1:    next_idx = 2'd2;
      default: next_idx = 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] i);
    case (i)
      2'd0:    onehot3 = 3'b001;
      2'd1:    onehot3 = 3'b010;
      2'd2:    onehot3 = 3'b100;
      default: onehot3 = 3'b000;
    endcase
  endfunction

  // A write needs a single WAIT cycle; a read waits out the BRAM latency.
  assign wait_done_s = op_wr_r | (wait_cnt_r == WAIT_LAST);

  // Winner selection: the lock owner exclusively, otherwise round-robin after ptr_r.
  always_comb begin
    c0_s        = next_idx(ptr_r);
    c1_s        = next_idx(c0_s);
    win_valid_s = 1'b0;
    win_idx_s   = 2'd0;
    if (state_r != S_IDLE) begin
      win_valid_s = 1'b0;
    end else if (owner_valid_r) begin
      win_valid_s = req[owner_r];
      win_idx_s   = owner_r;
    end else if (req[c0_s]) begin
      win_valid_s = 1'b1;
      win_idx_s   = c0_s;
    end else if (req[c1_s]) begin
      win_valid_s = 1'b1;
      win_idx_s   = c1_s;
    end else if (req[ptr_r]) begin
      win_valid_s = 1'b1;
      win_idx_s   = ptr_r;
    end else begin
      win_valid_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (win_valid_s) state_nxt_s = S_ISSUE;
        else             state_nxt_s = S_IDLE;
      end
      S_ISSUE: state_nxt_s = S_WAIT;
      S_WAIT: begin
        if (wait_done_s) state_nxt_s = S_IDLE;
        else             state_nxt_s = S_WAIT;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= S_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Registered BRAM port, grant/rvalid pulses, RR pointer, lock ownership and timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gnt             <= 3'b000;
      rvalid          <= 3'b000;
      rdata           <= {DATA_W{1'b0}};
      lock_timeout    <= 1'b0;
      bram_map_addr   <= {ADDR_W{1'b0}};
      bram_map_wr     <= 1'b0;
      bram_map_dwrite <= {DATA_W{1'b0}};
      ptr_r           <= 2'd2;
      owner_r         <= 2'd0;
      owner_valid_r   <= 1'b0;
      cur_r           <= 2'd0;
      op_wr_r         <= 1'b0;
      wait_cnt_r      <= 2'd0;
      tmo_cnt_r       <= {TMO_W{1'b0}};
    end else begin
      gnt          <= 3'b000;
      rvalid       <= 3'b000;
      lock_timeout <= 1'b0;
      bram_map_wr  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (win_valid_s) begin
            gnt             <= onehot3(win_idx_s);
            bram_map_addr   <= addr[int'(win_idx_s)*ADDR_W +: ADDR_W];
            bram_map_wr     <= wr[win_idx_s];
            bram_map_dwrite <= wdata[int'(win_idx_s)*DATA_W +: DATA_W];
            cur_r           <= win_idx_s;
            op_wr_r         <= wr[win_idx_s];
            tmo_cnt_r       <= {TMO_W{1'b0}};
          end else if (owner_valid_r) begin
            // Owner idle: count towards a forced release.
            if (tmo_cnt_r == TMO_LAST) begin
              owner_valid_r <= 1'b0;
              lock_timeout  <= 1'b1;
              tmo_cnt_r     <= {TMO_W{1'b0}};
            end else begin
              tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
          end else begin
            tmo_cnt_r <= {TMO_W{1'b0}};
          end
        end
        S_ISSUE: begin
          ptr_r         <= cur_r;
          owner_r       <= cur_r;
          owner_valid_r <= lock[cur_r];
          tmo_cnt_r     <= {TMO_W{1'b0}};
          wait_cnt_r    <= 2'd0;
        end
        S_WAIT: begin
          if (wait_done_s) begin
            if (!op_wr_r) begin
              rdata  <= bram_map_data;
              rvalid <= onehot3(cur_r);
            end else begin
              rdata <= rdata;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + 2'd1;
          end
        end
        default: begin
          gnt <= 3'b000;
        end
      endcase
    end
  end

endmodule
